uart_tx_hamming: RTL and testbench

- UART transmitter for the Hamming(7,4) link; the transmit end of the same frame format our UART receiver decodes.
- Accepts a 4-bit nibble over a valid/ready handshake and encodes it to a 7-bit Hamming codeword.
- Serialises each frame as: start bit (low), 7 codeword bits LSB first, stop bit(s) (high). Idle line is high.
- Sits between the nibble source and the tx pin/loopback.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/hamming74_encoder.sv | 12 +
 rtl/uart_tx_hamming.sv | 90 +++++++++
 tb/tb_uart_tx_hamming.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the Hamming(7,4) UART link (transmitter and receiver sides)
// Contents: HAMMING_W codeword width, state_t frame states IDLE/START/DATA/STOP,
//           parity functions p1/p2/p4 and the full codeword builder hamming_encode.
package uart_pkg;

    localparam int HAMMING_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    function automatic logic p1(input logic [3:0] d);
        return d[0] ^ d[1] ^ d[3];
    endfunction

    function automatic logic p2(input logic [3:0] d);
        return d[0] ^ d[2] ^ d[3];
    endfunction

    function automatic logic p4(input logic [3:0] d);
        return d[1] ^ d[2] ^ d[3];
    endfunction

    // bit i of the codeword is Hamming position i+1
    function automatic logic [HAMMING_W-1:0] hamming_encode(input logic [3:0] d);
        return {d[3], d[2], d[1], p4(d), d[0], p2(d), p1(d)};
    endfunction

endpackage

// File: rtl/hamming74_encoder.sv
// hamming74_encoder: combinational Hamming(7,4) encoder
// Ports: data [3:0] nibble in (d3..d0), code [6:0] codeword out {d3,d2,d1,p4,d0,p2,p1}.
module hamming74_encoder
    import uart_pkg::*;
(
    input  logic [3:0]           data,
    output logic [HAMMING_W-1:0] code
);

    assign code = hamming_encode(data);

endmodule

// File: rtl/uart_tx_hamming.sv
// uart_tx_hamming: UART transmitter sending one Hamming(7,4) codeword per frame
// Ports: clk, rst_n (async, active-low), ena (clock enable), data_in [3:0] + valid_in / ready_out
//        handshake, tx serial line (idle high), busy, tx_done (one-cycle frame-end pulse),
//        state_out [2:0] = {1'b0, state}.
// Frame: start bit (low), 7 codeword bits LSB first, STOP_BITS stop bits (high).
module uart_tx_hamming
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [3:0] data_in,
    input  logic       valid_in,
    output logic       ready_out,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic [2:0] state_out
);

    localparam int             SW        = $clog2(CLKS_PER_BIT) < 1 ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [SW-1:0]  SMP_LAST  = SW'(CLKS_PER_BIT - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

    state_t                 state, state_nx;
    logic [SW-1:0]          smp, smp_nx;
    logic [2:0]             bit_cnt, bit_nx;
    logic                   stop_cnt, stop_nx;
    logic [HAMMING_W-1:0]   shift, shift_nx, cw;
    logic                   tx_nx, bit_end;

    hamming74_encoder u_enc (
        .data (data_in),
        .code (cw)
    );

    always_comb begin
        bit_end  = smp == SMP_LAST;
        state_nx = state;
        smp_nx   = (state == IDLE || bit_end) ? '0 : smp + 1'b1;
        bit_nx   = state == DATA ? bit_cnt + {2'b0, bit_end} : 3'd0;
        stop_nx  = state == STOP ? stop_cnt ^ bit_end : 1'b0;
        shift_nx = (state == DATA && bit_end) ? shift >> 1 : shift;
        // tx follows the current state, so the line lags the state by one enabled edge
        tx_nx    = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    state_nx = START;
                    shift_nx = cw;
                end
            end
            START:   if (bit_end) state_nx = DATA;
            DATA:    if (bit_end && bit_cnt == 3'd6) state_nx = STOP;
            default: if (bit_end && stop_cnt == STOP_LAST) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            smp      <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            shift    <= '0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
        end else begin
            // the pulse clears on every edge, enabled or not
            tx_done <= 1'b0;
            if (ena) begin
                state    <= state_nx;
                smp      <= smp_nx;
                bit_cnt  <= bit_nx;
                stop_cnt <= stop_nx;
                shift    <= shift_nx;
                tx       <= tx_nx;
                tx_done  <= state == STOP && state_nx == IDLE;
            end
        end
    end

    assign ready_out = state == IDLE && ena;
    assign busy      = state != IDLE;
    assign state_out = {1'b0, state};

endmodule

// File: tb/tb_uart_tx_hamming.sv
// tb_uart_tx_hamming: scoreboard bench for uart_tx_hamming (CLKS_PER_BIT=8, STOP_BITS=1)
module tb_uart_tx_hamming;

    logic       clk = 1'b0;
    logic       rst_n, ena, valid_in, ready_out, tx, busy, tx_done;
    logic [3:0] data_in;
    logic [2:0] state_out;

    int         total = 0, bad = 0, cyc = 0, acc_cyc = 0, done_cyc = 0, frames = 0;
    logic [6:0] sb[$];
    bit         act = 0, tog = 0, en_q = 1'b1;

    uart_tx_hamming #(.CLKS_PER_BIT(8), .STOP_BITS(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done),
        .state_out (state_out)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        en_q <= ena;
    end

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic a, b, c;
        a = d[0] ^ d[1] ^ d[3];
        b = d[0] ^ d[2] ^ d[3];
        c = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], c, d[0], b, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ena toggles every cycle while tog is set; changes land between posedge and negedge
    initial forever begin
        @(posedge clk);
        #2;
        ena = tog ? ~ena : 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (tx_done) done_cyc = cyc;
    end

    // receiver model: one sample per enabled edge, 72 samples per frame
    initial begin
        int s, bi;
        logic e;
        logic [6:0] exp_cw, rx_cw;
        s = 0;
        exp_cw = '0;
        rx_cw = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) act = 0;
            else if (en_q) begin
                if (!act && tx === 1'b0) begin
                    s = 0;
                    rx_cw = '0;
                    if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
                    else begin
                        exp_cw = sb.pop_front();
                        act = 1;
                    end
                end
                if (act) begin
                    bi = s / 8;
                    e = bi == 0 ? 1'b0 : bi <= 7 ? exp_cw[bi-1] : 1'b1;
                    chk("tx_bit", 32'(tx), 32'(e));
                    chk("tx_done", 32'(tx_done), 32'(s == 71));
                    if (s % 8 == 4 && bi >= 1 && bi <= 7) rx_cw[bi-1] = tx;
                    s++;
                    if (s == 72) begin
                        chk("rx_cw", 32'(rx_cw), 32'(exp_cw));
                        frames++;
                        act = 0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [3:0] d, input bit hold);
        int n = 0;
        data_in = d;
        valid_in = 1'b1;
        while (!ready_out && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            chk("accept_to", 32'd0, 32'd1);
            valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(enc(d));
        @(negedge clk);
        acc_cyc = cyc;
        if (!hold) valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || act || state_out != 3'd0) && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_to", 32'(n < 6000), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int a1, a2, a3, n;
        rst_n = 1'b0;
        ena = 1'b1;
        valid_in = 1'b0;
        data_in = 4'h0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(tx_done), 32'd0);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_ready", 32'(ready_out), 32'd1);
        rst_n = 1'b1;
        repeat (50) begin
            @(negedge clk);
            chk("idle_tx", 32'(tx), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ready", 32'(ready_out), 32'd1);
            chk("idle_state", 32'(state_out), 32'd0);
        end

        send(4'hB, 1'b0);
        a1 = acc_cyc;
        chk("busy", 32'(busy), 32'd1);
        chk("state_start", 32'(state_out), 32'd1);
        chk("ready_busy", 32'(ready_out), 32'd0);
        wait_idle();
        chk("done_lat", 32'(done_cyc - a1), 32'd72);

        send(4'h1, 1'b1);
        a1 = acc_cyc;
        send(4'h2, 1'b1);
        a2 = acc_cyc;
        send(4'h3, 1'b0);
        a3 = acc_cyc;
        chk("period1", 32'(a2 - a1), 32'd73);
        chk("period2", 32'(a3 - a2), 32'd73);
        wait_idle();

        for (int i = 0; i < 16; i++) send(4'(i), i < 15);
        wait_idle();

        tog = 1;
        send(4'h6, 1'b0);
        a1 = acc_cyc;
        wait_idle();
        chk("ena_stretch", 32'(done_cyc - a1 > 100), 32'd1);
        send(4'h9, 1'b0);
        wait_idle();
        tog = 0;
        repeat (3) @(negedge clk);

        send(4'h5, 1'b0);
        n = 0;
        while (!(state_out == 3'd2 && tx == 1'b0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("data_to", 32'(n < 500), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx), 32'd1);
        chk("mid_rst_state", 32'(state_out), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(4'hA, 1'b0);
        a1 = acc_cyc;
        wait_idle();
        chk("post_rst_lat", 32'(done_cyc - a1), 32'd72);

        chk("frames", 32'(frames), 32'd23);
        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
